// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: burst-locked round-robin arbiter sharing one async FIFO write port
// among N requesters. Runs entirely in the FIFO write clock domain.
//
// Optional feature macro: FIFO_ARB_FIXED_PRIO_EN
//   defined   -> IDLE winner is the lowest-index requesting bit (no rotation)
//   undefined -> round-robin starting from rr_ptr
//
// Ports:
//   wr_clk, wr_reset_n    write clock, async active-low reset
//   req/req_last/req_data per-requester beat valid, end-of-burst, packed data
//   ack                   combinational beat-accept per requester
//   gnt                   registered one-hot grant
//   fifo_full             FIFO full flag (same-cycle timing)
//   fifo_wr_en/_data      FIFO write port
//   busy                  a grant is active
//   burst_trunc           one-cycle pulse when a grant is released at MAX_BURST
module fifo_wr_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BW        = 5
) (
  input  logic           wr_clk,
  input  logic           wr_reset_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_last,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   gnt,
  input  logic           fifo_full,
  output logic           fifo_wr_en,
  output logic [W-1:0]   fifo_wr_data,
  output logic           busy,
  output logic           burst_trunc
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            burst_trunc_q, burst_trunc_d;

  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            grant_last;
  logic            at_max;

  // Winner search: scan candidates from farthest to nearest so the nearest
  // requesting index (upward from the start point, wrapping) overwrites last.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      cand = IW'(k);
`else
      cand = IW'((int'(rr_ptr_q) + k) % int'(N));
`endif
      if (req[cand]) win_idx = cand;
    end
  end

  // gnt_q is zero outside a burst, so masking with it covers the IDLE case.
  always_comb begin
    ack        = gnt_q & req & {N{~fifo_full}};
    fifo_wr_en = |ack;
    fifo_wr_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (ack[i]) fifo_wr_data = req_data[i*W +: W];
    end
  end

  assign gnt         = gnt_q;
  assign busy        = (state_q == StBurst);
  assign burst_trunc = burst_trunc_q;
  assign grant_last  = req_last[gnt_idx_q];
  assign at_max      = (beat_cnt_q == BW'(MAX_BURST - 1));

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    beat_cnt_d    = beat_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    burst_trunc_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StBurst;
          gnt_d      = '0;
          gnt_d[win_idx] = 1'b1;
          gnt_idx_d  = win_idx;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        // Beat counter only moves on accepted beats, so full/req-low freeze it.
        if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (grant_last || at_max) begin
            state_d       = StIdle;
            gnt_d         = '0;
            burst_trunc_d = ~grant_last;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            rr_ptr_d = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      state_q       <= StIdle;
      gnt_q         <= '0;
      gnt_idx_q     <= '0;
      beat_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      burst_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gnt_idx_q     <= gnt_idx_d;
      beat_cnt_q    <= beat_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_trunc_q <= burst_trunc_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: self-checking bench for fifo_wr_arb. Requesters are driven from
// per-requester burst queues with random data; a transaction-level model predicts
// every output each cycle.
module tb_fifo_wr_arb;

  localparam int N         = 4;
  localparam int W         = 8;
  localparam int MAX_BURST = 4;
  localparam int BW        = 3;

  logic           wr_clk;
  logic           wr_reset_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic           busy;
  logic           burst_trunc;

  fifo_wr_arb #(
    .N(N), .W(W), .MAX_BURST(MAX_BURST), .BW(BW)
  ) dut (
    .wr_clk(wr_clk),
    .wr_reset_n(wr_reset_n),
    .req(req),
    .req_last(req_last),
    .req_data(req_data),
    .ack(ack),
    .gnt(gnt),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .busy(busy),
    .burst_trunc(burst_trunc)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side stimulus state.
  int           bq [N][$];
  int           rem [N];
  bit           drop [N];
  logic [W-1:0] cur_data [N];

  // Reference model: owner of the port (-1 when none), beats taken, next start.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_trunc = 1'b0;

  logic [N-1:0] prev_gnt = '0;
  int           grant_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic advance(input logic [N-1:0] acc);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        rem[i]--;
        cur_data[i] = W'($urandom);
      end
      if (rem[i] == 0 && bq[i].size() > 0) begin
        rem[i]      = bq[i].pop_front();
        cur_data[i] = W'($urandom);
      end
      req[i]              = (rem[i] > 0) && !drop[i];
      req_last[i]         = (rem[i] == 1);
      req_data[i*W +: W]  = cur_data[i];
    end
  endtask

  task automatic cycle();
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_ack;
    logic [W-1:0] e_data;
    int           base;
    @(negedge wr_clk);
    e_gnt  = '0;
    e_ack  = '0;
    e_data = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      if (req[m_owner] && !fifo_full) begin
        e_ack  = e_gnt;
        e_data = cur_data[m_owner];
      end
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("ack", 32'(ack), 32'(e_ack));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(|e_ack));
    check("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("burst_trunc", 32'(burst_trunc), 32'(m_trunc));
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) grant_log.push_back(i);
    end
    prev_gnt = gnt;
    // Model step for the coming edge.
    m_trunc = 1'b0;
    if (m_owner < 0) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      base = 0;
`else
      base = m_ptr;
`endif
      for (int k = 0; k < N; k++) begin
        if (req[(base + k) % N]) begin
          m_owner = (base + k) % N;
          m_cnt   = 0;
          break;
        end
      end
    end else if (e_ack != '0) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MAX_BURST) begin
        m_trunc = !req_last[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge wr_clk);
    #1;
    advance(e_ack);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    int exp_order [8];
    wr_reset_n = 1'b0;
    req        = '0;
    req_last   = '0;
    req_data   = '0;
    fifo_full  = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; drop[i] = 1'b0; cur_data[i] = '0;
    end

    // Reset state.
    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_trunc", 32'(burst_trunc), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    #9 wr_reset_n = 1'b1;
    @(posedge wr_clk);
    #1;

    // Requester 0: 3-beat burst, then idle.
    bq[0].push_back(3);
    advance('0);
    run(6);

    // Requester 2 with full asserted for 5 cycles mid-burst.
    bq[2].push_back(4);
    advance('0);
    run(3);
    fifo_full = 1'b1;
    run(5);
    fifo_full = 1'b0;
    run(4);

    // Requester 3 drops req for 3 cycles mid-burst.
    bq[3].push_back(3);
    advance('0);
    run(2);
    drop[3] = 1'b1;
    advance('0);
    run(3);
    drop[3] = 1'b0;
    advance('0);
    run(4);

    // All four requesters, two single-beat bursts each.
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      bq[i].push_back(1);
      bq[i].push_back(1);
    end
    advance('0);
    run(20);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    check("order_len", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size()) check("order", 32'(grant_log[k]), 32'(exp_order[k]));
    end

    // Requester 1: 6 beats, truncated after MAX_BURST then regranted.
    bq[1].push_back(6);
    advance('0);
    run(11);

    // Start bursts on 1 and 3, reset mid-burst, then lowest index must win.
    bq[1].push_back(3);
    bq[3].push_back(5);
    advance('0);
    run(3);
    #1 wr_reset_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_trunc = 1'b0;
    prev_gnt = '0;
    grant_log.delete();
    #1 wr_reset_n = 1'b1;
    run(3);
    check("post_rst_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
    run(12);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && bq[i].size() == 0 && $urandom_range(0, 5) == 0)
          bq[i].push_back(int'($urandom_range(1, 7)));
      end
      advance('0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
